ysyx_22040931_mem_arbiter: RTL and testbench
============================================

Name: ysyx_22040931_mem_arbiter

Overview:
- Shares one memory port between instruction fetch (IF) and load/store (LSU).
- Sits between the IF/LSU stages and the memory/bus bridge.
- One outstanding transaction at a time; request fields are registered.
- LSU has priority, with a streak limit so fetch is never starved. A pending fetch response is squashed when the front end is flushed.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data width; the write mask is DATA_W/8 bits
LS_STREAK, 4, maximum consecutive LSU grants while IF is pending before IF wins a tie (must be at least 1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
if_req_valid  in  1  fetch request valid
if_req_ready  out  1  fetch request accepted this cycle
if_addr  in  ADDR_W  fetch address
if_flush  in  1  front-end flush; squashes a fetch request or in-flight fetch
if_rsp_valid  out  1  fetch data valid (1-cycle pulse)
if_rsp_data  out  DATA_W  fetch data
ls_req_valid  in  1  LSU request valid
ls_req_ready  out  1  LSU request accepted this cycle
ls_addr  in  ADDR_W  LSU address
ls_wen  in  1  1 = write, 0 = read
ls_wdata  in  DATA_W  write data
ls_wmask  in  DATA_W/8  byte write mask
ls_rsp_valid  out  1  LSU completion (1-cycle pulse; read data on ls_rsp_data)
ls_rsp_data  out  DATA_W  load data
mem_req_valid  out  1  downstream request valid
mem_req_ready  in  1  downstream request accepted
mem_addr  out  ADDR_W  registered address
mem_wen  out  1  registered write enable
mem_wdata  out  DATA_W  registered write data
mem_wmask  out  DATA_W/8  registered write mask
mem_rsp_valid  in  1  downstream response valid
mem_rsp_data  in  DATA_W  downstream response data
busy  out  1  state is not IDLE

Behaviour:
- FSM states: IDLE, REQ, WAIT. Registers: owner (0 = IF, 1 = LS), drop, streak (3 bits, saturating at LS_STREAK).
- Arbitration (IDLE only, combinational):
  - ife = if_req_valid & ~if_flush.
  - ls_win = ls_req_valid & ~(ife & streak == LS_STREAK).
  - ls_req_ready = IDLE & ls_win.
  - if_req_ready = IDLE & ife & ~ls_win.
  - Both readies are 0 in REQ and WAIT.
- Accept (upstream valid & ready): latch addr, wen, wdata and wmask into the mem_* registers, set owner, clear drop, go to REQ.
  - An IF grant forces mem_wen = 0 and mem_wmask = 0.
- Streak update on every grant:
  - LS grant while ife: streak += 1 (saturating).
  - IF grant: streak = 0.
  - LS grant without ife: streak = 0.
- REQ: mem_req_valid = 1, fields held stable; on mem_req_ready go to WAIT. Latency from grant to mem_req_valid is 1 cycle.
- WAIT:
  - On mem_rsp_valid, go to IDLE.
  - The same cycle, combinationally:
    - if_rsp_valid = (owner == IF) & ~drop & ~if_flush.
    - ls_rsp_valid = (owner == LS).
  - Both rsp_data outputs equal mem_rsp_data.
  - A new grant is possible the next cycle, so back-to-back transactions take at least 3 cycles each.
- Flush:
  - if_flush in REQ or WAIT with owner == IF sets drop. The downstream transaction still completes (no abort), but its response is not forwarded.
  - if_flush in IDLE blocks a fetch grant that cycle.
  - if_flush has no effect on an LS-owned transaction.
- mem_rsp_valid outside WAIT is ignored.
- Reset (synchronous, at any point, including mid-transaction):
  - State goes to IDLE; owner, drop and streak are cleared.
  - mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask = 0.
  - busy = 0; all readies and rsp_valids = 0.
  - A late response arriving after reset is ignored.
- Simultaneous if/ls valid with streak below LS_STREAK: LS wins. With streak == LS_STREAK: IF wins.

Test Plan:
- Single fetch: if_req_valid with if_addr=0x8000_0000, mem_req_ready=1, response 2 cycles later with data 0x13 -> grant at t0; mem_req_valid at t1 with mem_addr 0x8000_0000, mem_wen=0; if_rsp_valid pulses with data 0x13 when mem_rsp_valid rises; ls_rsp_valid stays 0.
- LSU write with held handshake: ls_wen=1, addr 0x100, wdata 0xDEAD, wmask 0xFF, mem_req_ready low for 3 cycles -> mem_* fields stable and mem_req_valid high for all 3 cycles; WAIT entered after ready rises; ls_rsp_valid pulses once.
- Contention: if and ls valid continuously, LS_STREAK=4 -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- Flush in WAIT: fetch outstanding, if_flush pulsed before mem_rsp_valid -> if_rsp_valid never asserts; busy drops after the response; next fetch is accepted normally.
- Flush in IDLE with if_req_valid -> if_req_ready = 0 that cycle; grant occurs on the next cycle without flush.
- Reset in REQ, then a stray mem_rsp_valid -> all outputs 0, state IDLE, no rsp_valid pulses; the next request proceeds normally.

Source files
------------

// File: rtl/ysyx_22040931_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22040931_mem_arbiter
//
// Shares a single downstream memory port between the instruction-fetch (IF)
// and load/store (LSU) stages. Only one transaction is outstanding at a time.
// The request fields of the granted requester are captured into the mem_*
// registers and held stable until the downstream port accepts them.
//
// The LSU normally wins arbitration. A streak counter tracks consecutive LSU
// grants taken while a fetch was waiting; once it reaches LS_STREAK the fetch
// wins the next tie, so the front end cannot be starved. A front-end flush
// squashes a fetch that is still waiting for a grant, and marks an in-flight
// fetch so its response is swallowed when it arrives.
//
// Ports
//   clock, reset          : clock and synchronous active-high reset
//   if_req_valid/ready    : fetch request handshake, if_addr = fetch address
//   if_flush              : front-end flush
//   if_rsp_valid/data     : fetch response (single-cycle pulse)
//   ls_req_valid/ready    : LSU request handshake
//   ls_addr/wen/wdata/wmask : LSU request payload
//   ls_rsp_valid/data     : LSU completion (single-cycle pulse, load data)
//   mem_req_valid/ready   : downstream request handshake
//   mem_addr/wen/wdata/wmask : registered downstream request payload
//   mem_rsp_valid/data    : downstream response
//   busy                  : a transaction is in progress
// ---------------------------------------------------------------------------
module ysyx_22040931_mem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned LS_STREAK = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_rsp_valid,
    output logic [DATA_W-1:0]     if_rsp_data,

    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic                  ls_wen,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_wmask,
    output logic                  ls_rsp_valid,
    output logic [DATA_W-1:0]     ls_rsp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data,

    output logic                  busy
);

    localparam int unsigned MASK_W   = DATA_W / 8;
    localparam int unsigned STREAK_W = 3;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LS_STREAK);

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  owner;
    logic                  drop;
    logic [STREAK_W-1:0]   streak;

    logic                  ife;
    logic                  ls_win;
    logic                  if_grant;
    logic                  ls_grant;
    logic                  rsp_fire;

    // Arbitration: LSU wins unless a fetch is pending and the LSU streak
    // has reached its limit. Grants only happen in IDLE and never in reset.
    always_comb begin
        ife      = if_req_valid & ~if_flush;
        ls_win   = ls_req_valid & ~(ife & (streak == STREAK_MAX));
        ls_grant = ~reset & (state == S_IDLE) & ls_win;
        if_grant = ~reset & (state == S_IDLE) & ife & ~ls_win;
    end

    assign ls_req_ready = ls_grant;
    assign if_req_ready = if_grant;

    // Response routing: a flushed fetch (recorded in drop, or flushed in the
    // very cycle the data returns) is completed downstream but not forwarded.
    always_comb begin
        rsp_fire     = ~reset & (state == S_WAIT) & mem_rsp_valid;
        if_rsp_valid = rsp_fire & (owner == OWNER_IF) & ~drop & ~if_flush;
        ls_rsp_valid = rsp_fire & (owner == OWNER_LS);
    end

    assign if_rsp_data = mem_rsp_data;
    assign ls_rsp_data = mem_rsp_data;

    assign mem_req_valid = (state == S_REQ);
    assign busy          = (state != S_IDLE);

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (if_grant || ls_grant) state_nxt = S_REQ;
            S_REQ:  if (mem_req_ready)        state_nxt = S_WAIT;
            S_WAIT: if (mem_rsp_valid)        state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ownership, flush tracking and LSU streak counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner  <= OWNER_IF;
            drop   <= 1'b0;
            streak <= '0;
        end else begin
            if (if_grant || ls_grant) begin
                owner <= ls_grant ? OWNER_LS : OWNER_IF;
                drop  <= 1'b0;
            end else if ((state != S_IDLE) && (owner == OWNER_IF) && if_flush) begin
                drop  <= 1'b1;
            end

            // Only LSU grants that actually overtook a waiting fetch count.
            if (ls_grant) begin
                if (ife) begin
                    if (streak != STREAK_MAX) begin
                        streak <= streak + STREAK_W'(1);
                    end
                end else begin
                    streak <= '0;
                end
            end else if (if_grant) begin
                streak <= '0;
            end
        end
    end

    // Request payload capture; a fetch is always a plain read.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (ls_grant) begin
            mem_addr  <= ls_addr;
            mem_wen   <= ls_wen;
            mem_wdata <= ls_wdata;
            mem_wmask <= ls_wmask;
        end else if (if_grant) begin
            mem_addr  <= if_addr;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= MASK_W'(0);
        end
    end

endmodule

// File: tb/tb_ysyx_22040931_mem_arbiter.sv
module tb_ysyx_22040931_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned MW = DW / 8;

    logic            clock;
    logic            reset;
    logic            if_req_valid;
    logic            if_req_ready;
    logic [AW-1:0]   if_addr;
    logic            if_flush;
    logic            if_rsp_valid;
    logic [DW-1:0]   if_rsp_data;
    logic            ls_req_valid;
    logic            ls_req_ready;
    logic [AW-1:0]   ls_addr;
    logic            ls_wen;
    logic [DW-1:0]   ls_wdata;
    logic [MW-1:0]   ls_wmask;
    logic            ls_rsp_valid;
    logic [DW-1:0]   ls_rsp_data;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [AW-1:0]   mem_addr;
    logic            mem_wen;
    logic [DW-1:0]   mem_wdata;
    logic [MW-1:0]   mem_wmask;
    logic            mem_rsp_valid;
    logic [DW-1:0]   mem_rsp_data;
    logic            busy;

    ysyx_22040931_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .LS_STREAK(4)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_addr(if_addr), .if_flush(if_flush),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
        .ls_addr(ls_addr), .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .busy(busy)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        bit            chk_wdata;
    } mreq_t;

    mreq_t         exp_mem[$];
    logic [DW-1:0] exp_if[$];
    logic [DW-1:0] exp_ls[$];
    bit            exp_grant[$];   // 0 = IF, 1 = LS

    int   total = 0;
    int   bad   = 0;
    logic rdy_en;
    int   rsp_delay;
    int   stray_req;

    assign mem_req_ready = rdy_en;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream data returned for an address.
    function automatic logic [DW-1:0] rsp_for(input logic [AW-1:0] a);
        if (a == 32'h8000_0000) return 64'h13;
        return {32'h0, a ^ 32'h5A5A_5A5A};
    endfunction

    // Memory model: answers each accepted request rsp_delay cycles after the
    // handshake, and can inject stray responses on demand.
    initial begin
        bit            hs;
        logic [AW-1:0] ha;
        bit            pend;
        int            cnt;
        logic [AW-1:0] pa;
        int            stray_done;
        pend = 0; cnt = 0; pa = '0; stray_done = 0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clock);
            hs = mem_req_valid && mem_req_ready && !reset;
            ha = mem_addr;
            @(posedge clock);
            #1;
            mem_rsp_valid = 1'b0;
            if (reset) pend = 0;
            if (hs) begin
                pend = 1; cnt = rsp_delay; pa = ha;
            end
            if (stray_done != stray_req) begin
                stray_done++;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
            end else if (pend) begin
                if (cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = rsp_for(pa);
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: compares grants, downstream requests and responses against
    // the scoreboard queues.
    initial begin
        bit    if_hs;
        bit    ls_hs;
        mreq_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if_hs = if_req_valid && if_req_ready;
                ls_hs = ls_req_valid && ls_req_ready;
                if (if_hs || ls_hs) begin
                    if (exp_grant.size() == 0) chk("grant_unexpected", 64'(1), 64'(0));
                    else chk("grant_order", 64'(ls_hs), 64'(exp_grant.pop_front()));
                end
                if (mem_req_valid) begin
                    if (exp_mem.size() == 0) begin
                        chk("mem_req_unexpected", 64'(1), 64'(0));
                    end else begin
                        e = exp_mem[0];
                        chk("mem_addr",  64'(mem_addr),  64'(e.addr));
                        chk("mem_wen",   64'(mem_wen),   64'(e.wen));
                        chk("mem_wmask", 64'(mem_wmask), 64'(e.wmask));
                        if (e.chk_wdata) chk("mem_wdata", mem_wdata, e.wdata);
                        if (mem_req_ready) void'(exp_mem.pop_front());
                    end
                end
                if (if_rsp_valid) begin
                    if (exp_if.size() == 0) chk("if_rsp_unexpected", 64'(1), 64'(0));
                    else chk("if_rsp_data", if_rsp_data, exp_if.pop_front());
                end
                if (ls_rsp_valid) begin
                    if (exp_ls.size() == 0) chk("ls_rsp_unexpected", 64'(1), 64'(0));
                    else chk("ls_rsp_data", ls_rsp_data, exp_ls.pop_front());
                end
            end
        end
    end

    task automatic wait_accept(input bit is_ls);
        int n;
        bit got;
        n = 0; got = 0;
        while (!got && n < 50) begin
            @(negedge clock);
            got = is_ls ? (ls_req_ready === 1'b1) : (if_req_ready === 1'b1);
            n++;
        end
        chk("accept_seen", 64'(got), 64'(1));
        @(posedge clock);
        #1;
    endtask

    task automatic issue_if(input logic [AW-1:0] a, input bit want_rsp);
        exp_grant.push_back(1'b0);
        exp_mem.push_back('{addr: a, wen: 1'b0, wdata: '0, wmask: '0, chk_wdata: 1'b0});
        if (want_rsp) exp_if.push_back(rsp_for(a));
        if_req_valid = 1'b1;
        if_addr      = a;
        wait_accept(1'b0);
        if_req_valid = 1'b0;
    endtask

    task automatic issue_ls(input logic [AW-1:0] a, input logic w,
                            input logic [DW-1:0] d, input logic [MW-1:0] m);
        exp_grant.push_back(1'b1);
        exp_mem.push_back('{addr: a, wen: w, wdata: d, wmask: m, chk_wdata: 1'b1});
        exp_ls.push_back(rsp_for(a));
        ls_req_valid = 1'b1;
        ls_addr = a; ls_wen = w; ls_wdata = d; ls_wmask = m;
        wait_accept(1'b1);
        ls_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        bit done;
        n = 0; done = 0;
        while (!done && n < 100) begin
            @(posedge clock);
            #2;
            done = !busy && exp_if.size() == 0 && exp_ls.size() == 0 && exp_mem.size() == 0;
            n++;
        end
        chk("idle_reached", 64'(done), 64'(1));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},          64'(busy),          64'(0));
        chk({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'(0));
        chk({tag, "_mem_addr"},      64'(mem_addr),      64'(0));
        chk({tag, "_mem_wen"},       64'(mem_wen),       64'(0));
        chk({tag, "_mem_wdata"},     mem_wdata,          64'(0));
        chk({tag, "_mem_wmask"},     64'(mem_wmask),     64'(0));
        chk({tag, "_if_req_ready"},  64'(if_req_ready),  64'(0));
        chk({tag, "_ls_req_ready"},  64'(ls_req_ready),  64'(0));
        chk({tag, "_if_rsp_valid"},  64'(if_rsp_valid),  64'(0));
        chk({tag, "_ls_rsp_valid"},  64'(ls_rsp_valid),  64'(0));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        if_req_valid = 1'b0; if_addr = '0; if_flush = 1'b0;
        ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
        rdy_en = 1'b1; rsp_delay = 0; stray_req = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_quiet("reset");

        // Single fetch: request visible one cycle after the grant.
        @(posedge clock); #1;
        exp_grant.push_back(1'b0);
        exp_mem.push_back('{addr: 32'h8000_0000, wen: 1'b0, wdata: '0, wmask: '0, chk_wdata: 1'b0});
        exp_if.push_back(64'h13);
        if_req_valid = 1'b1; if_addr = 32'h8000_0000;
        wait_accept(1'b0);
        if_req_valid = 1'b0;
        @(negedge clock);
        chk("fetch_latency_valid", 64'(mem_req_valid), 64'(1));
        wait_idle();

        // LSU write held off by the downstream port for three cycles.
        rdy_en = 1'b0;
        issue_ls(32'h100, 1'b1, 64'hDEAD, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("ls_hold_valid", 64'(mem_req_valid), 64'(1));
        end
        @(posedge clock); #1;
        rdy_en = 1'b1;
        wait_idle();

        // Contention: expect LS x4 then IF, twice.
        if_addr = 32'h8000_1000;
        ls_addr = 32'h200; ls_wen = 1'b0; ls_wdata = 64'h1111_2222; ls_wmask = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                exp_grant.push_back(1'b0);
                exp_mem.push_back('{addr: 32'h8000_1000, wen: 1'b0, wdata: '0, wmask: '0, chk_wdata: 1'b0});
                exp_if.push_back(rsp_for(32'h8000_1000));
            end else begin
                exp_grant.push_back(1'b1);
                exp_mem.push_back('{addr: 32'h200, wen: 1'b0, wdata: 64'h1111_2222, wmask: 8'h00, chk_wdata: 1'b1});
                exp_ls.push_back(rsp_for(32'h200));
            end
        end
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clock);
            if (if_req_ready || ls_req_ready) n++;
        end
        @(posedge clock); #1;
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        chk("contention_grants", 64'(n), 64'(10));
        wait_idle();

        // Flush while the fetch is in WAIT: response swallowed.
        rsp_delay = 3;
        issue_if(32'h8000_2000, 1'b0);
        @(posedge clock); #1;
        if_flush = 1'b1;
        @(posedge clock); #1;
        if_flush = 1'b0;
        wait_idle();
        chk("flush_wait_busy", 64'(busy), 64'(0));
        rsp_delay = 0;
        issue_if(32'h8000_2008, 1'b1);
        wait_idle();

        // Flush in IDLE blocks the grant for that cycle only.
        exp_grant.push_back(1'b0);
        exp_mem.push_back('{addr: 32'h8000_3000, wen: 1'b0, wdata: '0, wmask: '0, chk_wdata: 1'b0});
        exp_if.push_back(rsp_for(32'h8000_3000));
        if_req_valid = 1'b1; if_addr = 32'h8000_3000; if_flush = 1'b1;
        @(negedge clock);
        chk("flush_idle_ready", 64'(if_req_ready), 64'(0));
        @(posedge clock); #1;
        if_flush = 1'b0;
        @(negedge clock);
        chk("flush_idle_next_ready", 64'(if_req_ready), 64'(1));
        @(posedge clock); #1;
        if_req_valid = 1'b0;
        wait_idle();

        // Reset while in REQ, then a stray response.
        rdy_en = 1'b0;
        issue_if(32'h8000_4000, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_mem.delete();
        stray_req = 1;
        rdy_en = 1'b1;
        @(negedge clock);
        chk_quiet("reset_mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stray_busy", 64'(busy), 64'(0));
            chk("stray_if_rsp", 64'(if_rsp_valid), 64'(0));
            chk("stray_ls_rsp", 64'(ls_rsp_valid), 64'(0));
        end
        @(posedge clock); #1;
        issue_ls(32'h300, 1'b0, 64'h0, 8'h00);
        wait_idle();

        chk("left_grant", 64'(exp_grant.size()), 64'(0));
        chk("left_mem",   64'(exp_mem.size()),   64'(0));
        chk("left_if",    64'(exp_if.size()),    64'(0));
        chk("left_ls",    64'(exp_ls.size()),    64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
